// File: rtl/cc_scheduler.sv
// cc_scheduler -- clock-compensation scheduler for the simplex Aurora TX path.
//
// Claims the lanes for a CC_LEN-cycle CC ordered-set burst every CC_PERIOD
// cycles and holds off the AXI-stream source with axi_ready while the burst runs.
// It also tracks frame boundaries. With CC_SCHED_DEFER_EN defined, a due burst
// waits for a frame gap for up to MAX_DEFER cycles before it preempts the frame.
//
// Ports:
//   clk                    system clock
//   rst_n                  synchronous, active-low reset
//   channel_init_finished  lane init done; the scheduler idles while low
//   axi_valid / axi_last   source beat valid / last beat of frame
//   axi_ready              beat accepted when axi_valid & axi_ready
//   cc_insert              datapath emits a CC ordered set this cycle
//   cc_first               first cycle of a CC burst
//   cc_preempt             burst started while a frame was open (one cycle)
//
// Optional feature macro: CC_SCHED_DEFER_EN (adds the PENDING state and defer_cnt).
module cc_scheduler #(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 6,
  parameter int MAX_DEFER = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic channel_init_finished,
  input  logic axi_valid,
  input  logic axi_last,
  output logic axi_ready,
  output logic cc_insert,
  output logic cc_first,
  output logic cc_preempt
);

  localparam int PW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int LW = (CC_LEN > 1)    ? $clog2(CC_LEN)    : 1;

  localparam logic [PW-1:0] PERIOD_MAX = PW'(CC_PERIOD - 1);
  localparam logic [LW-1:0] LEN_MAX    = LW'(CC_LEN - 1);

  localparam logic [1:0] S_DISABLED = 2'd0;
  localparam logic [1:0] S_COUNT    = 2'd1;
  localparam logic [1:0] S_PENDING  = 2'd2;
  localparam logic [1:0] S_CC       = 2'd3;

  // A burst (plus any deferral) must finish before the next wrap, because
  // due events are only acted on in COUNT and are never queued.
  if (CC_PERIOD <= CC_LEN + MAX_DEFER) begin : g_bad_params
    $error("cc_scheduler: CC_PERIOD must exceed CC_LEN + MAX_DEFER");
  end

  logic [1:0]    state;
  logic [PW-1:0] period_cnt;
  logic [LW-1:0] len_cnt;
  logic          in_frame;

`ifdef CC_SCHED_DEFER_EN
  localparam int DW = (MAX_DEFER > 1) ? $clog2(MAX_DEFER) : 1;
  localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER - 1);
  logic [DW-1:0] defer_cnt;
`endif

  logic          accept;
  logic          in_frame_nxt;
  logic          due;
  logic [PW-1:0] period_inc;

  assign accept       = axi_valid & axi_ready;
  // Frame state as it will be after this cycle's beat.
  assign in_frame_nxt = accept ? ~axi_last : in_frame;
  assign due          = (state == S_COUNT) && (period_cnt == PERIOD_MAX);
  assign period_inc   = (period_cnt == PERIOD_MAX) ? '0 : period_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n || !channel_init_finished) begin
      // Init loss takes priority over every transition.
      state      <= S_DISABLED;
      period_cnt <= '0;
      len_cnt    <= '0;
      in_frame   <= 1'b0;
`ifdef CC_SCHED_DEFER_EN
      defer_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_DISABLED: begin
          state      <= S_COUNT;
          period_cnt <= '0;
        end
        S_COUNT: begin
          period_cnt <= period_inc;
          in_frame   <= in_frame_nxt;
          if (due) begin
`ifdef CC_SCHED_DEFER_EN
            if (in_frame_nxt) state <= S_PENDING;
            else              state <= S_CC;
`else
            state <= S_CC;
`endif
          end
        end
`ifdef CC_SCHED_DEFER_EN
        S_PENDING: begin
          period_cnt <= period_inc;
          in_frame   <= in_frame_nxt;
          defer_cnt  <= defer_cnt + 1'b1;
          if ((accept && axi_last) || (defer_cnt == DEFER_MAX)) begin
            state     <= S_CC;
            defer_cnt <= '0;
          end
        end
`endif
        S_CC: begin
          // axi_ready is low here, so in_frame simply holds.
          period_cnt <= period_inc;
          len_cnt    <= len_cnt + 1'b1;
          if (len_cnt == LEN_MAX) begin
            len_cnt <= '0;
            state   <= S_COUNT;
          end
        end
        default: state <= S_DISABLED;
      endcase
    end
  end

  assign axi_ready  = (state == S_COUNT) || (state == S_PENDING);
  assign cc_insert  = (state == S_CC);
  assign cc_first   = cc_insert && (len_cnt == '0);
  assign cc_preempt = cc_first && in_frame;

endmodule

// File: tb/tb_cc_scheduler.sv
// Self-checking bench for cc_scheduler. A grid-based reference model predicts
// every output each cycle: bursts are due at t0 + k*P (k >= 1), where t0 is the
// first enabled cycle. Directed scenarios add literal expectations on top.
module tb_cc_scheduler;

  localparam int P  = 20;
  localparam int L  = 4;
  localparam int MD = 8;
`ifdef CC_SCHED_DEFER_EN
  localparam bit DEFER = 1'b1;
`else
  localparam bit DEFER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, cif, axi_valid, axi_last;
  logic axi_ready, cc_insert, cc_first, cc_preempt;

  always #5 clk = ~clk;

  cc_scheduler #(.CC_PERIOD(P), .CC_LEN(L), .MAX_DEFER(MD)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .channel_init_finished (cif),
    .axi_valid             (axi_valid),
    .axi_last              (axi_last),
    .axi_ready             (axi_ready),
    .cc_insert             (cc_insert),
    .cc_first              (cc_first),
    .cc_preempt            (cc_preempt)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state.
  bit m_en = 1'b0;
  bit m_if = 1'b0;
  int m_t0 = 0;
  int m_burst = -1;   // index within burst, -1 when none
  int m_defer = -1;   // deferral age, -1 when not deferring
  bit pend = 1'b0;    // source holding an unaccepted beat
  bit pend_l = 1'b0;

  logic e_ready, e_ins, e_first, e_pre;
  logic d_ready, d_ins, d_first, d_pre;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // One cycle: check outputs mid-cycle, drive inputs, advance the model.
  task automatic step(input bit r, input bit c, input bit v, input bit l);
    bit acc;
    @(negedge clk);
    if (m_en && m_burst < 0 && m_defer < 0 && cyc > m_t0 && ((cyc - m_t0) % P) == 0) begin
      if (DEFER && m_if) m_defer = 0;
      else               m_burst = 0;
    end
    e_ready = m_en && (m_burst < 0);
    e_ins   = (m_burst >= 0);
    e_first = (m_burst == 0);
    e_pre   = e_first && m_if;
    d_ready = axi_ready; d_ins = cc_insert; d_first = cc_first; d_pre = cc_preempt;
    chk("axi_ready", d_ready, e_ready);
    chk("cc_insert", d_ins, e_ins);
    chk("cc_first", d_first, e_first);
    chk("cc_preempt", d_pre, e_pre);

    if (pend) begin v = 1'b1; l = pend_l; end
    rst_n = r; cif = c; axi_valid = v; axi_last = l;
    acc    = v && e_ready;
    pend   = v && !e_ready;
    pend_l = l;

    if (!r || !c) begin
      m_en = 1'b0; m_burst = -1; m_defer = -1; m_if = 1'b0;
    end else if (!m_en) begin
      m_en = 1'b1; m_t0 = cyc + 1;
    end else begin
      if (m_defer >= 0) begin
        if ((acc && l) || m_defer == MD - 1) begin m_defer = -1; m_burst = 0; end
        else m_defer++;
      end else if (m_burst >= 0) begin
        m_burst++;
        if (m_burst == L) m_burst = -1;
      end
      if (acc) m_if = !l;
    end
    cyc++;
  endtask

  initial begin
    int npre;
    rst_n = 1'b0; cif = 1'b0; axi_valid = 1'b0; axi_last = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held, then init low for 10 cycles: everything idle.
    repeat (2) step(0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      step(1, 0, 1, 0);
      chk("idle_ready", d_ready, 1'b0);
      chk("idle_insert", d_ins, 1'b0);
    end

    // Init rises at cycle 5, single-beat frames: bursts 26-29 and 46-49.
    for (int c = 0; c < 56; c++) begin
      step(1, c >= 5, 1, 1);
      chk("grid_ready", d_ready, (c >= 6) && !((c >= 26 && c <= 29) || (c >= 46 && c <= 49)));
      chk("grid_first", d_first, (c == 26) || (c == 46));
    end

`ifndef CC_SCHED_DEFER_EN
    // Open frame at due: burst on time, one preempt pulse.
    step(1, 0, 0, 0);
    npre = 0;
    for (int c = 0; c < 31; c++) begin
      step(1, 1, 1, 0);
      npre += int'(d_pre);
      if (c == 21) begin
        chk("pre_first", d_first, 1'b1);
        chk("pre_pulse", d_pre, 1'b1);
      end
    end
    chki("pre_count", npre, 1);
`else
    // Frame never ends: deferral times out, burst at 29 preempts.
    step(1, 0, 0, 0);
    for (int c = 0; c < 41; c++) begin
      step(1, 1, 1, 0);
      if (c >= 21 && c <= 28) chk("dto_ready", d_ready, 1'b1);
      if (c == 29) begin
        chk("dto_first", d_first, 1'b1);
        chk("dto_pre", d_pre, 1'b1);
      end
      if (c == 33) chk("dto_resume", d_ready, 1'b1);
    end
    // Last beat 3 cycles after due: burst at 25, next on grid at 41.
    step(1, 0, 0, 0);
    npre = 0;
    for (int c = 0; c < 46; c++) begin
      step(1, 1, 1, c >= 24);
      npre += int'(d_pre);
      if (c == 25 || c == 41 || c == 21) chk("dgap_first", d_first, c != 21);
    end
    chki("dgap_pre_count", npre, 0);
`endif

    // Init dropped on the second burst cycle, then re-enabled.
    step(1, 0, 0, 0);
    for (int c = 0; c < 52; c++) begin
      step(1, !(c >= 22 && c <= 24), 1, 1);
      if (c == 22) chk("drop_ins_before", d_ins, 1'b1);
      if (c == 23) begin
        chk("drop_ins", d_ins, 1'b0);
        chk("drop_ready", d_ready, 1'b0);
      end
      if (c == 45) chk("reen_not_yet", d_ins, 1'b0);
      if (c == 46) chk("reen_first", d_first, 1'b1);
    end

    // Randomized traffic, alternating short and long frames.
    for (int c = 0; c < 4000; c++) begin
      bit lng;
      lng = ((c / 500) % 2) == 1;
      step($urandom_range(0, 599) != 0,
           $urandom_range(0, 299) != 0,
           $urandom_range(0, 3) != 0,
           lng ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
